// File: rtl/alu_sequencer_if.sv
// Fetch and ALU bus between the sequencer (master) and the instruction source / ALU / IO (slave).
interface alu_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] pc;
    logic                instr_valid;
    logic                instr_ready;
    logic [7:0]          instr_data;
    logic [2:0]          alu_opcode;
    logic [7:0]          alu_operand_a;
    logic [7:0]          alu_operand_b;
    logic [7:0]          alu_result;
    logic [7:0]          in_data;
    logic [7:0]          out_data;
    logic                out_strobe;

    modport master (
        output pc, instr_ready, alu_opcode, alu_operand_a, alu_operand_b, out_data, out_strobe,
        input  instr_valid, instr_data, alu_result, in_data
    );

    modport slave (
        input  pc, instr_ready, alu_opcode, alu_operand_a, alu_operand_b, out_data, out_strobe,
        output instr_valid, instr_data, alu_result, in_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/issue sequencer for the 8-bit CPU: immediate, compute (via external ALU),
// copy/IO and conditional-jump instructions over a 6-entry register file.
module alu_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    alu_sequencer_if.master   bus
);

    typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          regs_q [6];
    logic [7:0]          regs_d [6];
    logic [2:0]          alu_opcode_q, alu_opcode_d;
    logic [7:0]          alu_a_q, alu_a_d;
    logic [7:0]          alu_b_q, alu_b_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_strobe_q, out_strobe_d;

    logic [1:0] mode;
    logic [2:0] fld_s;
    logic [2:0] fld_d;
    logic [7:0] copy_src;
    logic       r3_zero;
    logic       r3_neg;
    logic       cond_base;
    logic       jump_taken;

    assign mode  = ir_q[7:6];
    assign fld_s = ir_q[5:3];
    assign fld_d = ir_q[2:0];

    always_comb begin
        copy_src = 8'h00;
        case (fld_s)
            3'd6:    copy_src = bus.in_data;
            3'd7:    copy_src = 8'h00;
            default: copy_src = regs_q[fld_s];
        endcase
    end

    // Upper condition bit inverts the base test: never/==0/<0/<=0 become always/!=0/>=0/>0.
    assign r3_zero = (regs_q[3] == 8'h00);
    assign r3_neg  = regs_q[3][7];
    always_comb begin
        cond_base = 1'b0;
        case (fld_d[1:0])
            2'd0: cond_base = 1'b0;
            2'd1: cond_base = r3_zero;
            2'd2: cond_base = r3_neg;
            2'd3: cond_base = r3_neg | r3_zero;
            default: cond_base = 1'b0;
        endcase
    end
    assign jump_taken = cond_base ^ fld_d[2];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        regs_d       = regs_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + PC_WIDTH'(1);
                case (mode)
                    2'b00: regs_d[0] = {2'b00, ir_q[5:0]};
                    2'b01: begin
                        alu_opcode_d = fld_d;
                        alu_a_d      = regs_q[1];
                        alu_b_d      = regs_q[2];
                        state_d      = WB;
                    end
                    2'b10: begin
                        if (fld_d == 3'd6) begin
                            out_data_d   = copy_src;
                            out_strobe_d = 1'b1;
                        end else if (fld_d != 3'd7) begin
                            regs_d[fld_d] = copy_src;
                        end
                    end
                    default: begin
                        if (jump_taken) pc_d = PC_WIDTH'(regs_q[0]);
                    end
                endcase
            end
            WB: begin
                regs_d[3] = bus.alu_result;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pc_q         <= PC_WIDTH'(RESET_PC);
            ir_q         <= 8'h00;
            for (int i = 0; i < 6; i++) regs_q[i] <= 8'h00;
            alu_opcode_q <= 3'd0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            out_data_q   <= 8'h00;
            out_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            regs_q       <= regs_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.instr_ready   = (state_q == FETCH);
    assign bus.alu_opcode    = alu_opcode_q;
    assign bus.alu_operand_a = alu_a_q;
    assign bus.alu_operand_b = alu_b_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_strobe    = out_strobe_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expected output writes and ALU issues,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_alu_sequencer;

    logic clock;
    logic reset_n;

    alu_sequencer_if #(.PC_WIDTH(8)) bus();

    alu_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_t;

    logic [7:0] exp_out_q [$];
    alu_t       exp_alu_q [$];
    int tests = 0;
    int fails = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALU: 100 add, 101 subtract, everything else returns zero.
    assign bus.alu_result = (bus.alu_opcode == 3'b100) ? bus.alu_operand_a + bus.alu_operand_b :
                            (bus.alu_opcode == 3'b101) ? bus.alu_operand_a - bus.alu_operand_b :
                            8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (bus.instr_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL fetch_timeout: instr_ready got %b expected 1", bus.instr_ready);
        end
    endtask

    task automatic issue(input logic [7:0] ins);
        wait_fetch();
        $display("[TB] issue pc=%02h instr=%02h", bus.pc, ins);
        bus.instr_valid = 1'b1;
        bus.instr_data  = ins;
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'hFF;
    endtask

    task automatic check_pc(input string name, input logic [7:0] exp);
        wait_fetch();
        chk(name, bus.pc, exp);
    endtask

    task automatic push_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_t t;
        t.op = op; t.a = a; t.b = b;
        exp_alu_q.push_back(t);
    endtask

    // Monitor: output writes on out_strobe, ALU issue on the second consecutive not-ready cycle (WB).
    initial begin
        logic prev_strobe = 1'b0;
        logic prev_ready  = 1'b1;
        logic [7:0] e;
        alu_t t;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.out_strobe) begin
                    tests++;
                    if (prev_strobe) begin
                        fails++;
                        $display("FAIL strobe_width: out_strobe got 1 expected 0 (high two cycles)");
                    end
                    if (exp_out_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL out_unexpected: got out_data %02h expected no write", bus.out_data);
                    end else begin
                        e = exp_out_q.pop_front();
                        $display("[TB] out write %02h (expected %02h)", bus.out_data, e);
                        chk("out_data", bus.out_data, e);
                    end
                end
                if (!bus.instr_ready && !prev_ready) begin
                    if (exp_alu_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL alu_unexpected: got op %0d expected no issue", bus.alu_opcode);
                    end else begin
                        t = exp_alu_q.pop_front();
                        $display("[TB] alu issue op=%03b a=%02h b=%02h", bus.alu_opcode,
                                 bus.alu_operand_a, bus.alu_operand_b);
                        chk("alu_opcode", {5'b0, bus.alu_opcode}, {5'b0, t.op});
                        chk("alu_operand_a", bus.alu_operand_a, t.a);
                        chk("alu_operand_b", bus.alu_operand_b, t.b);
                    end
                end
            end
            prev_strobe = bus.out_strobe;
            prev_ready  = bus.instr_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;
        bus.in_data     = 8'h00;
        #1;
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_ready", {7'b0, bus.instr_ready}, 8'h01);
        chk("rst_strobe", {7'b0, bus.out_strobe}, 8'h00);
        chk("rst_opcode", {5'b0, bus.alu_opcode}, 8'h00);
        chk("rst_out_data", bus.out_data, 8'h00);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Immediate to output
        issue(8'h2A);
        exp_out_q.push_back(8'h2A);
        issue(8'h86);
        check_pc("imm_out_pc", 8'h02);

        // ADD 5 + 3
        issue(8'h05); issue(8'h81); issue(8'h03); issue(8'h82);
        push_alu(3'b100, 8'h05, 8'h03);
        issue(8'h44);
        exp_out_q.push_back(8'h08);
        issue(8'h9E);
        check_pc("add_pc", 8'h08);

        // SUB 3 - 5 then conditional jumps on reg3=FE
        issue(8'h81); issue(8'h05); issue(8'h82);
        push_alu(3'b101, 8'h03, 8'h05);
        issue(8'h45);
        exp_out_q.push_back(8'hFE);
        issue(8'h9E);
        issue(8'h10);
        issue(8'hC2); check_pc("jmp_lt_taken", 8'h10);
        issue(8'hC1); check_pc("jmp_eq_not", 8'h11);
        issue(8'hC6); check_pc("jmp_ge_not", 8'h12);
        issue(8'hC5); check_pc("jmp_ne_taken", 8'h10);
        issue(8'hC0); check_pc("jmp_never", 8'h11);
        issue(8'hC3); check_pc("jmp_le_taken", 8'h10);
        issue(8'hC7); check_pc("jmp_gt_not", 8'h11);

        // PC wrap and input sampling
        bus.in_data = 8'hFF;
        issue(8'hB0);
        issue(8'hC4); check_pc("jmp_always_ff", 8'hFF);
        issue(8'h3F); check_pc("pc_wrap", 8'h00);
        exp_out_q.push_back(8'h3F);
        issue(8'h86);
        bus.in_data = 8'h77;
        issue(8'hB0);
        exp_out_q.push_back(8'h77);
        issue(8'h86);
        exp_out_q.push_back(8'h00);
        issue(8'hBE);
        check_pc("io_pc", 8'h04);

        // Stall: no valid instruction for 5 cycles
        bus.instr_data = 8'h3A;
        repeat (5) @(negedge clock);
        check_pc("stall_pc", 8'h04);
        exp_out_q.push_back(8'hFE);
        issue(8'h9E);

        // Reset during WB of an ADD (reg1=3, reg2=5)
        push_alu(3'b100, 8'h03, 8'h05);
        issue(8'h44);
        @(posedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("wbrst_pc", bus.pc, 8'h00);
        chk("wbrst_ready", {7'b0, bus.instr_ready}, 8'h01);
        chk("wbrst_strobe", {7'b0, bus.out_strobe}, 8'h00);
        chk("wbrst_opcode", {5'b0, bus.alu_opcode}, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        exp_out_q.push_back(8'h00);
        issue(8'h9E);
        check_pc("wbrst_after_pc", 8'h01);

        repeat (4) @(negedge clock);
        chk("out_queue_drained", 8'(exp_out_q.size()), 8'h00);
        chk("alu_queue_drained", 8'(exp_alu_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
